insn_id_tracker: RTL and testbench
==================================

Name: insn_id_tracker

Overview:
- Parametrised in-order instruction-ID allocator and completion scoreboard for the vector core dispatcher.
- Hands out insn_id values round-robin and records which vector functional units (VALU, VLU, VSU, ...) each instruction occupies.
- Collects per-unit done pulses, which may arrive out of order, and retires IDs strictly in allocation order.
- Generalises the fixed 3-bit ID / 3-VFU arrangement to arbitrary ID width and unit count, adding an occupancy count and protocol-error detection.

Parameters:
- IdWidth, 3, width of insn_id; NrId = 2**IdWidth entries tracked.
- NrUnit, 3, number of functional units that report completion; bit index equals the vfu_e encoding.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- alloc_valid_i  input  1  dispatcher requests a new ID.
- alloc_unit_mask_i  input  NrUnit  units that must report done for this instruction.
- alloc_ready_o  output  1  an ID is free.
- alloc_id_o  output  IdWidth  ID granted on an alloc handshake.
- done_valid_i  input  NrUnit  per-unit completion pulse.
- done_id_i  input  NrUnit*IdWidth  per-unit completed ID; slice u belongs to unit u.
- retire_valid_o  output  1  oldest instruction has completed on all its units.
- retire_id_o  output  IdWidth  ID of the oldest instruction.
- retire_ready_i  input  1  consumer accepts the retire.
- inflight_cnt_o  output  IdWidth+1  number of allocated, unretired IDs.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- State:
  - head_q and tail_q, each IdWidth+1 bits, with a wrap bit in the MSB.
  - pending_q: NrId x NrUnit bit matrix.
  - err_q.
- Empty when head_q == tail_q. Full when the low bits are equal and the wrap bits differ.
- Reset (async, rst_ni=0):
  - head_q = tail_q = 0, pending_q = 0, err_q = 0.
  - Outputs: alloc_ready_o=1, alloc_id_o=0, retire_valid_o=0, retire_id_o=0, inflight_cnt_o=0, err_o=0.
  - Reset mid-operation discards every in-flight ID; no retire is produced for them.
- Alloc:
  - alloc_ready_o = !full. alloc_id_o = tail_q[IdWidth-1:0], combinational.
  - On alloc_valid_i && alloc_ready_o: pending_q[tail] <= alloc_unit_mask_i; tail_q++.
  - alloc_ready_o does not depend on alloc_valid_i.
  - There is no same-cycle bypass: when full, a retire in cycle N frees a slot visible from cycle N+1.
- Done (each unit u independently, same cycle):
  - If done_valid_i[u], the ID is allocated (inside [head, tail)), and pending bit [id][u] is 1: clear the bit.
  - Otherwise the pulse is ignored and err_q <= 1.
  - Several units may complete the same or different IDs in one cycle; all valid clears apply.
  - A done pulse targeting the ID being allocated in the same cycle is an error, because that ID is not yet allocated.
  - A done pulse for the head ID in the same cycle it retires is an error; retire requires the bit already clear.
- Retire:
  - retire_valid_o = !empty && pending_q[head] == 0. retire_id_o = head_q[IdWidth-1:0].
  - Both are combinational from registered state, so the earliest retire_valid_o is the cycle after the last done.
  - An alloc with a zero mask is retire-eligible the cycle after allocation.
  - On retire_valid_o && retire_ready_i: head_q++. At most one retire per cycle.
  - retire_valid_o holds and retire_id_o stays stable until accepted.
- Occupancy:
  - inflight_cnt_o = tail_q - head_q, modulo 2**(IdWidth+1), range 0..NrId.
  - Simultaneous alloc and retire leave the count unchanged.
- Wrap-around: pointer low bits wrap NrId-1 -> 0 and the wrap bit toggles; IDs reused after wrap start with a freshly written mask.
- err_o = err_q. It is cleared only by reset.

Test Plan:
- Reset, then 8 allocs with mask 3'b001 and no done (IdWidth=3) -> IDs 0..7 granted; alloc_ready_o=0 after the 8th; inflight_cnt_o=8.
- Alloc ID0 mask 3'b011 and ID1 mask 3'b100; done VSU on ID1, then VALU+VLU on ID0 in the same cycle -> no retire before ID0 clears; retire 0 next cycle, then retire 1.
- Full tracker, retire ID0 with alloc_valid_i=1 in the same cycle -> no grant that cycle; next cycle grants ID0 with wrap bit toggled and inflight_cnt_o=8.
- Alloc mask 3'b000 -> retire_valid_o=1 one cycle later with that ID; hold retire_ready_i=0 for 3 cycles -> retire_valid_o and retire_id_o stable.
- Done on unallocated ID5 (empty tracker), or a second VALU done on an already-cleared bit -> err_o=1 next cycle and stays 1; scoreboard state unchanged.
- Assert rst_ni low asynchronously mid-stream with 4 in flight -> all outputs at reset values immediately; the next alloc grants ID0.

Source files
------------

// File: rtl/insn_id_tracker_if.sv
// Dispatcher-side handshake bundle for insn_id_tracker: alloc, per-unit done and retire.
interface insn_id_tracker_if #(
  parameter int IdWidth = 3,
  parameter int NrUnit  = 3
);
  logic                       alloc_valid_i;
  logic [NrUnit-1:0]          alloc_unit_mask_i;
  logic                       alloc_ready_o;
  logic [IdWidth-1:0]         alloc_id_o;
  logic [NrUnit-1:0]          done_valid_i;
  logic [NrUnit*IdWidth-1:0]  done_id_i;
  logic                       retire_valid_o;
  logic [IdWidth-1:0]         retire_id_o;
  logic                       retire_ready_i;
  logic [IdWidth:0]           inflight_cnt_o;
  logic                       err_o;

  modport master (
    output alloc_valid_i, alloc_unit_mask_i, done_valid_i, done_id_i, retire_ready_i,
    input  alloc_ready_o, alloc_id_o, retire_valid_o, retire_id_o, inflight_cnt_o, err_o
  );

  modport slave (
    input  alloc_valid_i, alloc_unit_mask_i, done_valid_i, done_id_i, retire_ready_i,
    output alloc_ready_o, alloc_id_o, retire_valid_o, retire_id_o, inflight_cnt_o, err_o
  );
endinterface

// File: rtl/insn_id_tracker.sv
// In-order instruction-ID allocator with per-unit completion scoreboard.
// Done pulses clear pending bits out of order; IDs retire strictly in allocation order.

// Per-unit done qualifier: a pulse is legal only for an in-flight ID whose bit is still set.
module insn_id_tracker_unit #(
  parameter int IdWidth = 3
) (
  input  logic                    done_valid,
  input  logic [IdWidth-1:0]      done_id,
  input  logic [IdWidth-1:0]      head_id,
  input  logic [IdWidth:0]        inflight,
  input  logic [(2**IdWidth)-1:0] pend_col,
  output logic [(2**IdWidth)-1:0] clr,
  output logic                    err
);
  logic [IdWidth-1:0] offs;
  logic               hit;

  always_comb begin
    // distance from head, modulo NrId; inside [head, tail) iff below occupancy
    offs = done_id - head_id;
    hit  = ({1'b0, offs} < inflight) && pend_col[done_id];
    clr  = '0;
    if (done_valid && hit) clr[done_id] = 1'b1;
    err  = done_valid && !hit;
  end
endmodule

module insn_id_tracker #(
  parameter int IdWidth = 3,
  parameter int NrUnit  = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  insn_id_tracker_if.slave    trk
);
  localparam int NrId = 2**IdWidth;

  logic [IdWidth:0]                head_q, tail_q, inflight;
  logic [NrId-1:0][NrUnit-1:0]     pending_q, pending_d;
  logic [NrUnit-1:0][NrId-1:0]     pend_t, clr;
  logic [NrUnit-1:0]               unit_err;
  logic                            err_q;
  logic                            full, empty, alloc_fire, retire_fire;
  logic [IdWidth-1:0]              head_id, tail_id;

  assign head_id  = head_q[IdWidth-1:0];
  assign tail_id  = tail_q[IdWidth-1:0];
  assign inflight = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_id == tail_id) && (head_q[IdWidth] != tail_q[IdWidth]);

  assign trk.alloc_ready_o  = !full;
  assign trk.alloc_id_o     = tail_id;
  assign trk.retire_valid_o = !empty && (pending_q[head_id] == '0);
  assign trk.retire_id_o    = head_id;
  assign trk.inflight_cnt_o = inflight;
  assign trk.err_o          = err_q;

  assign alloc_fire  = trk.alloc_valid_i && !full;
  assign retire_fire = trk.retire_valid_o && trk.retire_ready_i;

  always_comb begin
    pend_t = '0;
    for (int i = 0; i < NrId; i++)
      for (int u = 0; u < NrUnit; u++)
        pend_t[u][i] = pending_q[i][u];
  end

  for (genvar u = 0; u < NrUnit; u++) begin : g_unit
    insn_id_tracker_unit #(.IdWidth(IdWidth)) u_unit (
      .done_valid (trk.done_valid_i[u]),
      .done_id    (trk.done_id_i[u*IdWidth +: IdWidth]),
      .head_id    (head_id),
      .inflight   (inflight),
      .pend_col   (pend_t[u]),
      .clr        (clr[u]),
      .err        (unit_err[u])
    );
  end

  // The tail slot is never in flight, so alloc write and done clears never collide.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NrId; i++) begin
      for (int u = 0; u < NrUnit; u++)
        if (clr[u][i]) pending_d[i][u] = 1'b0;
      if (alloc_fire && (tail_id == IdWidth'(i)))
        pending_d[i] = trk.alloc_unit_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_q | (|unit_err);
      if (alloc_fire)  tail_q <= tail_q + (IdWidth+1)'(1);
      if (retire_fire) head_q <= head_q + (IdWidth+1)'(1);
    end
  end
endmodule

// File: tb/tb_insn_id_tracker.sv
// Bench for insn_id_tracker: vector table, directed corner sequences, and random traffic
// against a queue-based reference model.
module tb_insn_id_tracker;
  localparam int IW = 3;
  localparam int NU = 3;
  localparam int NR_ID = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  insn_id_tracker_if #(.IdWidth(IW), .NrUnit(NU)) bus ();
  insn_id_tracker #(.IdWidth(IW), .NrUnit(NU)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .trk(bus));

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference model: in-flight instructions in allocation order with their outstanding units.
  typedef struct { int id; logic [NU-1:0] mask; } ent_t;
  ent_t mq[$];
  int   m_next;
  bit   m_err;

  function automatic void m_reset();
    mq.delete();
    m_next = 0;
    m_err  = 0;
  endfunction

  function automatic bit m_rv();
    return (mq.size() > 0) && (mq[0].mask == '0);
  endfunction

  function automatic int m_rid();
    return (mq.size() > 0) ? mq[0].id : m_next;
  endfunction

  function automatic void m_update();
    bit   rv, rdy, ok;
    int   d;
    ent_t e;
    rv  = m_rv();
    rdy = mq.size() < NR_ID;
    for (int u = 0; u < NU; u++) begin
      if (bus.done_valid_i[u]) begin
        d  = int'(bus.done_id_i[u*IW +: IW]);
        ok = 0;
        for (int k = 0; k < mq.size(); k++)
          if (mq[k].id == d && mq[k].mask[u]) begin
            mq[k].mask[u] = 1'b0;
            ok = 1;
          end
        if (!ok) m_err = 1;
      end
    end
    if (rv && bus.retire_ready_i) void'(mq.pop_front());
    if (bus.alloc_valid_i && rdy) begin
      e.id   = m_next;
      e.mask = bus.alloc_unit_mask_i;
      mq.push_back(e);
      m_next = (m_next + 1) % NR_ID;
    end
  endfunction

  task automatic drive(input logic av, input logic [NU-1:0] am, input logic [NU-1:0] dv,
                       input logic [NU*IW-1:0] did, input logic rr);
    bus.alloc_valid_i     = av;
    bus.alloc_unit_mask_i = am;
    bus.done_valid_i      = dv;
    bus.done_id_i         = did;
    bus.retire_ready_i    = rr;
  endtask

  task automatic step();
    @(posedge clk_i);
    m_update();
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_rdy"}, int'(bus.alloc_ready_o), int'(mq.size() < NR_ID));
    chk({tag, "_aid"}, int'(bus.alloc_id_o), m_next);
    chk({tag, "_rv"},  int'(bus.retire_valid_o), int'(m_rv()));
    chk({tag, "_rid"}, int'(bus.retire_id_o), m_rid());
    chk({tag, "_cnt"}, int'(bus.inflight_cnt_o), mq.size());
    chk({tag, "_err"}, int'(bus.err_o), int'(m_err));
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_rdy"}, int'(bus.alloc_ready_o), 1);
    chk({tag, "_aid"}, int'(bus.alloc_id_o), 0);
    chk({tag, "_rv"},  int'(bus.retire_valid_o), 0);
    chk({tag, "_rid"}, int'(bus.retire_id_o), 0);
    chk({tag, "_cnt"}, int'(bus.inflight_cnt_o), 0);
    chk({tag, "_err"}, int'(bus.err_o), 0);
  endtask

  task automatic do_reset();
    drive(0, '0, '0, '0, 0);
    rst_ni = 1'b0;
    m_reset();
    #1;
    check_reset_vals("rst");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic av; logic [NU-1:0] am; logic [NU-1:0] dv; logic [NU*IW-1:0] did; logic rr;
    logic e_rdy; logic [IW-1:0] e_id; logic e_rv; logic [IW-1:0] e_rid; logic [IW:0] e_cnt; logic e_err;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(logic av, logic [NU-1:0] am, logic [NU-1:0] dv, logic [NU*IW-1:0] did,
                              logic rr, logic e_rdy, logic [IW-1:0] e_id, logic e_rv,
                              logic [IW-1:0] e_rid, logic [IW:0] e_cnt, logic e_err);
    vec_t v;
    v.av = av; v.am = am; v.dv = dv; v.did = did; v.rr = rr;
    v.e_rdy = e_rdy; v.e_id = e_id; v.e_rv = e_rv; v.e_rid = e_rid; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  logic [NU-1:0]    r_am, r_dv;
  logic [NU*IW-1:0] r_did;
  int               cand[$];

  initial begin
    // Expected outputs are those visible after the clock edge that applies each row.
    //            av am      dv      did           rr  rdy id rv rid cnt err
    tbl[0]  = mk(1, 3'b011, 3'b000, 9'o000,       0,  1, 1, 0, 0, 1, 0);
    tbl[1]  = mk(1, 3'b100, 3'b000, 9'o000,       0,  1, 2, 0, 0, 2, 0);
    tbl[2]  = mk(0, 3'b000, 3'b100, 9'o100,       0,  1, 2, 0, 0, 2, 0);
    tbl[3]  = mk(0, 3'b000, 3'b011, 9'o000,       0,  1, 2, 1, 0, 2, 0);
    tbl[4]  = mk(0, 3'b000, 3'b000, 9'o000,       1,  1, 2, 1, 1, 1, 0);
    tbl[5]  = mk(0, 3'b000, 3'b000, 9'o000,       1,  1, 2, 0, 2, 0, 0);
    tbl[6]  = mk(1, 3'b000, 3'b000, 9'o000,       0,  1, 3, 1, 2, 1, 0);
    tbl[7]  = mk(0, 3'b000, 3'b000, 9'o000,       0,  1, 3, 1, 2, 1, 0);
    tbl[8]  = mk(0, 3'b000, 3'b000, 9'o000,       0,  1, 3, 1, 2, 1, 0);
    tbl[9]  = mk(0, 3'b000, 3'b000, 9'o000,       0,  1, 3, 1, 2, 1, 0);
    tbl[10] = mk(0, 3'b000, 3'b000, 9'o000,       1,  1, 3, 0, 3, 0, 0);
    tbl[11] = mk(1, 3'b000, 3'b000, 9'o000,       0,  1, 4, 1, 3, 1, 0);
    tbl[12] = mk(1, 3'b001, 3'b000, 9'o000,       1,  1, 5, 0, 4, 1, 0);
    tbl[13] = mk(0, 3'b000, 3'b001, 9'o004,       0,  1, 5, 1, 4, 1, 0);
    tbl[14] = mk(0, 3'b000, 3'b000, 9'o000,       1,  1, 5, 0, 5, 0, 0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].av, tbl[i].am, tbl[i].dv, tbl[i].did, tbl[i].rr);
      step();
      chk($sformatf("vec%0d_rdy", i), int'(bus.alloc_ready_o), int'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_aid", i), int'(bus.alloc_id_o), int'(tbl[i].e_id));
      chk($sformatf("vec%0d_rv", i),  int'(bus.retire_valid_o), int'(tbl[i].e_rv));
      chk($sformatf("vec%0d_rid", i), int'(bus.retire_id_o), int'(tbl[i].e_rid));
      chk($sformatf("vec%0d_cnt", i), int'(bus.inflight_cnt_o), int'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_err", i), int'(bus.err_o), int'(tbl[i].e_err));
    end

    // Fill to full, then retire while alloc is requested: the freed slot appears next cycle.
    do_reset();
    for (int i = 0; i < NR_ID; i++) begin
      drive(1, 3'b001, '0, '0, 0);
      chk("fill_rdy", int'(bus.alloc_ready_o), 1);
      chk("fill_aid", int'(bus.alloc_id_o), i);
      step();
    end
    chk("full_rdy", int'(bus.alloc_ready_o), 0);
    chk("full_cnt", int'(bus.inflight_cnt_o), 8);
    drive(1, 3'b001, '0, '0, 0);
    step();
    chk("full_hold_cnt", int'(bus.inflight_cnt_o), 8);
    chk("full_hold_aid", int'(bus.alloc_id_o), 0);
    drive(1, 3'b001, 3'b001, 9'o000, 0);
    step();
    chk("full_done_rv", int'(bus.retire_valid_o), 1);
    chk("full_done_rid", int'(bus.retire_id_o), 0);
    drive(1, 3'b001, '0, '0, 1);
    chk("full_ret_rdy", int'(bus.alloc_ready_o), 0);
    step();
    chk("post_ret_rdy", int'(bus.alloc_ready_o), 1);
    chk("post_ret_aid", int'(bus.alloc_id_o), 0);
    chk("post_ret_cnt", int'(bus.inflight_cnt_o), 7);
    chk("post_ret_rid", int'(bus.retire_id_o), 1);
    drive(1, 3'b010, '0, '0, 0);
    step();
    chk("wrap_cnt", int'(bus.inflight_cnt_o), 8);
    chk("wrap_rdy", int'(bus.alloc_ready_o), 0);
    chk("wrap_aid", int'(bus.alloc_id_o), 1);
    check_model("wrap");

    // Done on an unallocated ID in an empty tracker.
    do_reset();
    drive(0, '0, 3'b001, 9'o005, 0);
    step();
    chk("err_unalloc", int'(bus.err_o), 1);
    chk("err_unalloc_cnt", int'(bus.inflight_cnt_o), 0);
    chk("err_unalloc_rv", int'(bus.retire_valid_o), 0);
    drive(0, '0, '0, '0, 0);
    step();
    step();
    chk("err_sticky", int'(bus.err_o), 1);

    // Second done on an already-cleared bit.
    do_reset();
    drive(1, 3'b001, '0, '0, 0);
    step();
    drive(0, '0, 3'b001, 9'o000, 0);
    step();
    chk("dup_first_err", int'(bus.err_o), 0);
    chk("dup_first_rv", int'(bus.retire_valid_o), 1);
    step();
    chk("dup_err", int'(bus.err_o), 1);
    chk("dup_rv", int'(bus.retire_valid_o), 1);
    chk("dup_rid", int'(bus.retire_id_o), 0);
    chk("dup_cnt", int'(bus.inflight_cnt_o), 1);

    // Done aimed at the ID being allocated in the same cycle.
    do_reset();
    drive(1, 3'b001, 3'b001, 9'o000, 0);
    step();
    chk("same_cyc_err", int'(bus.err_o), 1);
    chk("same_cyc_rv", int'(bus.retire_valid_o), 0);
    chk("same_cyc_cnt", int'(bus.inflight_cnt_o), 1);

    // Asynchronous reset mid-stream with four IDs in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'b000, '0, '0, 0);
      step();
    end
    drive(0, '0, '0, '0, 0);
    chk("pre_arst_cnt", int'(bus.inflight_cnt_o), 4);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals("arst");
    m_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(1, 3'b001, '0, '0, 0);
    chk("arst_next_aid", int'(bus.alloc_id_o), 0);
    step();
    chk("arst_after_aid", int'(bus.alloc_id_o), 1);
    chk("arst_after_cnt", int'(bus.inflight_cnt_o), 1);
    chk("arst_after_rv", int'(bus.retire_valid_o), 0);

    // Random traffic, mostly legal done pulses, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      r_am  = NU'($urandom_range(0, 7));
      r_dv  = '0;
      r_did = '0;
      for (int u = 0; u < NU; u++) begin
        cand.delete();
        for (int k = 0; k < mq.size(); k++)
          if (mq[k].mask[u]) cand.push_back(mq[k].id);
        if (cand.size() > 0 && $urandom_range(0, 99) < 40) begin
          r_dv[u] = 1'b1;
          r_did[u*IW +: IW] = IW'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 99) == 0) begin
          r_dv[u] = 1'b1;
          r_did[u*IW +: IW] = IW'($urandom_range(0, NR_ID - 1));
        end
      end
      drive(1'($urandom_range(0, 9) < 6), r_am, r_dv, r_did, 1'($urandom_range(0, 9) < 7));
      step();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
